// File: rtl/ps2_key_fifo.sv
// PS/2 make-code buffer: edge-detects new scancode bytes, optionally filters break/E0
// sequences (macro PS2_BREAK_FILTER_EN), and queues codes in a first-word-fall-through FIFO.
module ps2_key_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ps2_key_pressed,
    input  logic [7:0]    ps2_out,
    input  logic          pop,
    input  logic          clear_overflow,
    output logic          key_valid,
    output logic [7:0]    key_data,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam int unsigned CW = AW + 1;

    logic          kp_q;
    logic          accept_c;
    logic          push_c;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full_c, empty_c, do_push_c, do_pop_c, ovf_set_c;

    // kp_q resets high so a level held across reset release is not taken as a new byte
    always_ff @(posedge clock or posedge reset) begin
        if (reset) kp_q <= 1'b1;
        else       kp_q <= ps2_key_pressed;
    end

    assign accept_c = ps2_key_pressed & ~kp_q;

`ifdef PS2_BREAK_FILTER_EN
    typedef enum logic {ST_IDLE, ST_BREAK} state_t;
    state_t state_q, state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // E0 is a prefix in either state; F0 arms the discard of the following code
    always_comb begin
        state_d = state_q;
        push_c  = 1'b0;
        if (accept_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (ps2_out == 8'hF0)      state_d = ST_BREAK;
                    else if (ps2_out != 8'hE0) push_c  = 1'b1;
                end
                ST_BREAK: begin
                    if (ps2_out != 8'hE0) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
`else
    assign push_c = accept_c;
`endif

    assign full_c    = (count_q == CW'(DEPTH));
    assign empty_c   = (count_q == '0);
    assign do_pop_c  = pop & ~empty_c;
    assign do_push_c = push_c & (~full_c | do_pop_c);
    assign ovf_set_c = push_c & full_c & ~do_pop_c;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CW'(do_push_c) - CW'(do_pop_c);
        overflow_d = overflow_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (ovf_set_c)           overflow_d = 1'b1;
        else if (clear_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is reset so the head reads zero straight after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (do_push_c) begin
            mem_q[wr_ptr_q] <= ps2_out;
        end
    end

    assign key_valid = ~empty_c;
    assign key_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Self-checking bench for ps2_key_fifo: queue-based reference model plus directed scenarios.
module tb_ps2_key_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ps2_key_pressed = 1'b0;
    logic [7:0]    ps2_out = 8'h00;
    logic          pop = 1'b0;
    logic          clear_overflow = 1'b0;
    logic          key_valid;
    logic [7:0]    key_data;
    logic [AW:0]   count;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    ps2_key_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_out         (ps2_out),
        .pop             (pop),
        .clear_overflow  (clear_overflow),
        .key_valid       (key_valid),
        .key_data        (key_data),
        .count           (count),
        .overflow        (overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of codes, a level history and a "discard next code" flag
    logic [7:0] mq[$];
    logic       m_prev_level;
    logic       m_discard_next;
    logic       m_ovf;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_prev_level   = 1'b1;
            m_discard_next = 1'b0;
            m_ovf          = 1'b0;
        end else begin
            logic new_byte, keep, popping, ovf_now;
            new_byte = ps2_key_pressed && !m_prev_level;
            m_prev_level = ps2_key_pressed;
            keep = new_byte;
`ifdef PS2_BREAK_FILTER_EN
            if (new_byte) begin
                if (ps2_out == 8'hE0)    keep = 1'b0;
                else if (m_discard_next) begin keep = 1'b0; m_discard_next = 1'b0; end
                else if (ps2_out == 8'hF0) begin keep = 1'b0; m_discard_next = 1'b1; end
            end
`endif
            popping = pop && (mq.size() > 0);
            ovf_now = 1'b0;
            if (popping) void'(mq.pop_front());
            if (keep) begin
                if (mq.size() >= DEPTH) ovf_now = 1'b1;
                else                    mq.push_back(ps2_out);
            end
            if (ovf_now)             m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
        end
    end

    // Continuous comparison against the model on every falling edge out of reset
    always @(negedge clock) begin
        if (!reset) begin
            check("model_valid", 32'(key_valid), 32'(mq.size() > 0));
            check("model_count", 32'(count), 32'(mq.size()));
            check("model_overflow", 32'(overflow), 32'(m_ovf));
            if (mq.size() > 0) check("model_data", 32'(key_data), 32'(mq[0]));
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        ps2_out = b;
        ps2_key_pressed = 1'b1;
        repeat (hold) tick();
        ps2_key_pressed = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input logic [7:0] exp);
        check("pop_valid", 32'(key_valid), 32'd1);
        check("pop_data", 32'(key_data), 32'(exp));
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    logic [7:0] stream [8];

    initial begin
        stream = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_data", 32'(key_data), 32'h00);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single code with a long level: exactly one push
        send_byte(8'h1C, 5);
        check("single_count", 32'(count), 32'd1);
        check("single_data", 32'(key_data), 32'h1C);
        pop_expect(8'h1C);
        check("single_empty", 32'(key_valid), 32'd0);

        // Break filter stream
        for (int i = 0; i < 8; i++) send_byte(stream[i], 2);
`ifdef PS2_BREAK_FILTER_EN
        check("filter_count", 32'(count), 32'd2);
        pop_expect(8'h1C);
        pop_expect(8'h75);
`else
        check("raw_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) pop_expect(stream[i]);
`endif
        check("stream_empty", 32'(count), 32'd0);

        // Overflow: ninth code dropped
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) pop_expect(8'(i));
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO: push and pop in the same cycle
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), 1);
        ps2_out = 8'hAA;
        ps2_key_pressed = 1'b1;
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("fullpp_count", 32'(count), 32'd8);
        check("fullpp_overflow", 32'(overflow), 32'd0);
        ps2_key_pressed = 1'b0;
        tick();
        for (int i = 1; i < 8; i++) pop_expect(8'h11 + 8'(i));
        pop_expect(8'hAA);

        // Empty FIFO: push and pop in the same cycle
        ps2_out = 8'h33;
        ps2_key_pressed = 1'b1;
        pop = 1'b1;
        tick();
        pop = 1'b0;
        ps2_key_pressed = 1'b0;
        check("emptypp_count", 32'(count), 32'd1);
        tick();
        pop_expect(8'h33);

        // Overflow set and clear in the same cycle: set wins
        for (int i = 0; i < 8; i++) send_byte(8'h21 + 8'(i), 1);
        ps2_out = 8'h29;
        ps2_key_pressed = 1'b1;
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        ps2_key_pressed = 1'b0;
        check("setwins_overflow", 32'(overflow), 32'd1);
        tick();
        for (int i = 0; i < 8; i++) pop_expect(8'h21 + 8'(i));
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;

        // Wrap-around: 20 rounds of 3 pushes then 3 pops
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 3; k++) send_byte(8'h40 + 8'(r * 3 + k), 1);
            for (int k = 0; k < 3; k++) pop_expect(8'h40 + 8'(r * 3 + k));
        end
        check("wrap_count", 32'(count), 32'd0);

        // Reset with entries buffered, decoder armed and level held high
        for (int i = 0; i < 5; i++) send_byte(8'h51 + 8'(i), 1);
        send_byte(8'hF0, 1);
        ps2_out = 8'hE0;
        ps2_key_pressed = 1'b1;
        tick();
        #2 reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("rr_count", 32'(count), 32'd0);
        check("rr_valid", 32'(key_valid), 32'd0);
        check("rr_data", 32'(key_data), 32'h00);
        ps2_key_pressed = 1'b0;
        tick();
        send_byte(8'h1C, 2);
        check("rr_push_count", 32'(count), 32'd1);
        check("rr_push_data", 32'(key_data), 32'h1C);
        pop_expect(8'h1C);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_fifo.md
# ps2_key_fifo

Buffers keyboard bytes between the PS/2 interface and the processor. Each new byte from the PS/2 interface (a rising edge of `ps2_key_pressed`) passes through a small decoder that drops break sequences and `E0` prefixes. The resulting make codes go into a first-word-fall-through FIFO. The processor reads and pops key codes at its own pace, so no keystrokes are lost between polls.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; must be a power of two, at least 2.
- `AW`, default 3: pointer width, equal to log2(`DEPTH`).

Ports:
- `clock`, input, 1: single system clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `ps2_key_pressed`, input, 1: new-byte indication from the PS/2 interface; a level that may stay high for many cycles.
- `ps2_out`, input, 8: last scancode byte from the PS/2 interface; stable while `ps2_key_pressed` is high.
- `pop`, input, 1: processor consumes the head entry.
- `clear_overflow`, input, 1: clears the sticky overflow flag.
- `key_valid`, output, 1: FIFO is non-empty; `key_data` is valid.
- `key_data`, output, 8: head-of-FIFO make code (first-word fall-through).
- `count`, output, `AW+1`: number of occupied entries, 0 to `DEPTH`.
- `overflow`, output, 1: sticky; a code was dropped because the FIFO was full.

## Operation
- **Edge detect:**
  - The `kp_q` register samples `ps2_key_pressed` every cycle.
  - A new byte is accepted when `ps2_key_pressed`=1 and `kp_q`=0.
  - At most one byte is accepted per rising edge of `ps2_key_pressed`, however long the level stays high.
- **Decoder FSM:** states are IDLE and BREAK.
  - IDLE, byte `F0`: go to BREAK; nothing is pushed.
  - IDLE, byte `E0`: stay in IDLE; nothing is pushed.
  - IDLE, any other byte: push the byte; stay in IDLE.
  - BREAK, byte `E0`: stay in BREAK; nothing is pushed.
  - BREAK, any other byte (including `F0`): discard it and return to IDLE.
- **FIFO:**
  - Storage is `DEPTH` × 8 bits, with `AW`-bit write and read pointers that wrap modulo `DEPTH`.
  - `count` is held in a separate register.
  - Push when full (`count`=`DEPTH`) with no pop in the same cycle: the byte is dropped, `overflow` is set, and pointers and `count` are unchanged.
  - Pop when empty: ignored, no state change.
  - Push and pop in the same cycle with the FIFO non-empty: both happen and `count` is unchanged. This includes the full case; the push succeeds and `overflow` is not set.
  - Push and pop in the same cycle with the FIFO empty: the push happens and the pop is ignored.
- **Overflow flag:**
  - `clear_overflow` clears `overflow`.
  - If a new overflow and `clear_overflow` occur in the same cycle, the set wins and `overflow` stays 1.

## Timing
- **Reset values:**
  - `key_valid`=0, `key_data`=`8'h00`, `count`=0, `overflow`=0.
  - FSM in IDLE; both pointers 0.
  - `kp_q` resets to 1, so a `ps2_key_pressed` held high across reset release produces no push.
- **Reset mid-operation:** all buffered codes and the decoder state are lost immediately, asynchronously.
- **Push latency:** if the accepting edge is at clock edge k, `key_valid` and `key_data` reflect the pushed code after edge k, one cycle after `ps2_key_pressed` is first sampled high. This holds when the FIFO was empty.
- **Pop:**
  - `pop` sampled high at edge k with `key_valid`=1: after edge k, `key_data` shows the next entry, or `key_valid`=0 if that was the last entry.
  - Sustained single-cycle pops are supported at full rate.
- `key_data` is driven combinationally from storage at the read pointer. Its value is don't-care while `key_valid`=0, except after reset, when it reads 0.
- `count` and `overflow` are registered.

## Configuration
- Macro: `PS2_BREAK_FILTER_EN`.
- **Defined:** the decoder FSM operates as described in Operation, removing break sequences and `E0` prefixes.
- **Undefined:**
  - The FSM is compiled out.
  - Every accepted raw byte, including `F0` and `E0`, is pushed unchanged.
  - FIFO behaviour is identical.

## Test plan
- **Single code:** reset, then drive `ps2_out`=`1C` and raise `ps2_key_pressed` for 5 cycles.
  - Expect exactly one push: `key_valid`=1, `key_data`=`1C`, `count`=1.
  - Then `pop` for 1 cycle: expect `key_valid`=0, `count`=0.
- **Break filter:** send bytes `1C`, `F0`, `1C`, `E0`, `75`, `E0`, `F0`, `75`, each with its own rising edge.
  - Filter enabled: FIFO holds `1C`, `75` only, so `count`=2.
  - Filter disabled: `count`=8 and contents are in order.
- **Overflow:** push 9 distinct codes `01` to `09` without popping.
  - Expect `count`=8 and `overflow`=1.
  - Then 8 pops return `01` to `08`.
  - `clear_overflow` then gives `overflow`=0.
- **Simultaneous events:**
  - Full FIFO, push `AA` and pop in the same cycle: `count` stays 8 and `overflow` stays 0; the last entry popped later is `AA`.
  - Empty FIFO, push and pop in the same cycle: `count`=1.
  - Overflow set and `clear_overflow` in the same cycle: `overflow`=1.
- **Wrap-around:** 20 cycles of interleaved push and pop of 3 codes each. Data order is preserved across pointer wrap, and `count` never exceeds 8.
- **Reset:**
  - Reset asserted with 5 entries buffered, FSM in BREAK, and `ps2_key_pressed` held high through reset release.
  - After release: `count`=0, `key_valid`=0, and no push until `ps2_key_pressed` falls and rises again.
  - The next byte `1C` is pushed, confirming the FSM is in IDLE.
